// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit path.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Width of one transmitted character
  localparam int BYTE_W = 8;

  // Width of the inter-message idle gap counter
  localparam int GAP_CNT_W = 16;

  // 27 MHz / 115200 baud, used by the downstream serialiser
  localparam int BAUD_DIVISOR = 234;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request found searching circularly upward from ptr.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic             any
);

  logic             found;
  logic [PTR_W-1:0] sel;
  int               idx;

  // Walk the requests starting at ptr, wrapping at N_REQ; first hit wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        win[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Any request at all, independent of pointer position
  assign any = |req;

endmodule : rr_pick

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Message-granular round-robin arbiter sharing one UART byte
//               transmitter between N_REQ sources. An owner keeps the
//               transmitter until its last byte is accepted, then an optional
//               idle gap is inserted before the next arbitration.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_valid,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Gap counter reload: counts GAP_CYCLES-1 down to 0, one GAP cycle each
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
      (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  if (N_REQ < 1 || N_REQ > 8) begin : g_bad_n_req
    $error("uart_tx_arbiter: N_REQ must be 1..8");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 65535) begin : g_bad_gap
    $error("uart_tx_arbiter: GAP_CYCLES must be 0..65535");
  end

  arb_state_t           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [GAP_CNT_W-1:0] gap_cnt;

  logic [N_REQ-1:0]     pick_win;
  logic                 pick_any;
  logic [PTR_W-1:0]     owner_idx;
  logic [PTR_W-1:0]     next_ptr;
  logic                 last_hs;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .win (pick_win),
    .any (pick_any)
  );

  // Route the owner's byte stream to the serialiser; grant is zero outside BUSY
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        tx_valid     = req_valid[i];
        tx_data      = req_data[i*BYTE_W +: BYTE_W];
        req_ready[i] = tx_ready;
      end
    end
  end

  // Encode the one-hot owner and compute where the next search starts
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        owner_idx = PTR_W'(i);
      end
    end
    next_ptr = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;
  end

  // Final byte of the owner's message is being accepted this cycle
  assign last_hs = tx_valid & tx_ready & (|(grant & req_last));

  assign busy = (state != IDLE);

  // Arbitration FSM: pick in IDLE, hold through the message, then idle gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick_win;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (last_hs) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule : uart_tx_arbiter

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter. Requester drivers feed
//               per-source byte queues; expected (owner, byte) pairs are
//               queued as messages are loaded and a monitor checks every
//               accepted byte.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        busy;

  // Second instance with an idle gap between messages
  logic [1:0]  g_req_valid;
  logic [15:0] g_req_data;
  logic [1:0]  g_req_last;
  logic [1:0]  g_req_ready;
  logic        g_tx_valid;
  logic [7:0]  g_tx_data;
  logic [1:0]  g_grant;
  logic        g_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(0)) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_data (req_data), .req_last (req_last),
    .req_ready (req_ready), .tx_valid (tx_valid), .tx_data (tx_data),
    .tx_ready (tx_ready), .grant (grant), .busy (busy)
  );

  uart_tx_arbiter #(.N_REQ(2), .GAP_CYCLES(5)) dut_gap (
    .clk (clk), .reset (reset),
    .req_valid (g_req_valid), .req_data (g_req_data), .req_last (g_req_last),
    .req_ready (g_req_ready), .tx_valid (g_tx_valid), .tx_data (g_tx_data),
    .tx_ready (1'b1), .grant (g_grant), .busy (g_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Requester byte queues: bit 8 = last flag
  logic [8:0] mem [4][16];
  int         head [4];
  int         tail [4];

  // Expected accepted bytes: {owner one-hot, data}
  logic [11:0] exp_q [$];

  // Per-cycle samples taken at the falling edge
  logic [3:0] s_grant, s_req_ready;
  logic       s_busy, s_tx_valid;
  bit         bp_mode = 1'b0;

  task automatic push_byte(input int r, input logic [7:0] b, input logic last, input bit expect_it);
    mem[r][tail[r]] = {last, b};
    tail[r]++;
    if (expect_it) exp_q.push_back({4'(1 << r), b});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 4; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (head[i] != tail[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = mem[i][head[i]][7:0];
        req_last[i]         = mem[i][head[i]][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
  endtask

  // One clock: sample mid-cycle, then retire accepted bytes after the edge
  task automatic cycle();
    logic [3:0] hs;
    @(negedge clk);
    hs          = req_valid & req_ready;
    s_grant     = grant;
    s_req_ready = req_ready;
    s_busy      = busy;
    s_tx_valid  = tx_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) head[i]++;
    if (bp_mode) tx_ready = ~tx_ready;
    refresh();
  endtask

  task automatic run_until_empty(input int max_cyc, output int n);
    n = 0;
    while (!all_empty() && n < max_cyc) begin
      cycle();
      n++;
    end
    if (!all_empty()) chk("drain_timeout", 32'(n), 32'(max_cyc + 1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_queues();
    refresh();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // Monitor: check each accepted byte against the scoreboard and watch the
  // ownership rules every cycle
  logic       pend = 1'b0;
  logic [7:0] pend_data;
  always @(negedge clk) begin
    logic [11:0] e;
    if (pend) begin
      chk("hold_valid", 32'(tx_valid), 32'd1);
      chk("hold_data", 32'(tx_data), 32'(pend_data));
    end
    pend = 1'b0;
    if (!reset && tx_valid && !tx_ready) begin
      pend      = 1'b1;
      pend_data = tx_data;
    end
    if (busy) chk("nonowner_ready", 32'(req_ready & ~grant), 32'd0);
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {20'd0, grant, tx_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("tx_owner", 32'(grant), 32'(e[11:8]));
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int t_first;
    int t_second;
    logic [7:0] hello [7];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

    reset       = 1'b1;
    tx_ready    = 1'b1;
    g_req_valid = '0;
    g_req_data  = '0;
    g_req_last  = '0;
    clear_queues();
    refresh();

    // Reset state
    cycle();
    cycle();
    chk("rst_grant", 32'(s_grant), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_tx_valid", 32'(s_tx_valid), 32'd0);
    chk("rst_req_ready", 32'(s_req_ready), 32'd0);
    reset = 1'b0;

    // Single requester "Hello\r\n"
    for (int i = 0; i < 7; i++) push_byte(0, hello[i], (i == 6), 1'b1);
    refresh();
    cycle();
    chk("hello_idle_txv", 32'(s_tx_valid), 32'd0);
    cycle();
    chk("hello_grant", 32'(s_grant), 32'd1);
    chk("hello_first_txv", 32'(s_tx_valid), 32'd1);
    run_until_empty(20, n);
    chk("hello_no_bubbles", 32'(n), 32'd6);
    cycle();
    chk("hello_busy_drop", 32'(s_busy), 32'd0);

    // Contention: 0 and 2 together from reset
    do_reset();
    for (int i = 0; i < 3; i++) push_byte(0, 8'hA0 + 8'(i), (i == 2), 1'b1);
    for (int i = 0; i < 3; i++) push_byte(2, 8'hC0 + 8'(i), (i == 2), 1'b1);
    refresh();
    run_until_empty(30, n);
    chk("contend_cycles", 32'(n), 32'd8);
    // Pointer now at 3: requester 3 must beat requester 0
    push_byte(3, 8'h33, 1'b1, 1'b1);
    push_byte(0, 8'h00, 1'b1, 1'b1);
    refresh();
    run_until_empty(20, n);
    chk("ptr3_cycles", 32'(n), 32'd4);

    // Fairness: all four requesting 1-byte messages continuously
    do_reset();
    push_byte(0, 8'h10, 1'b1, 1'b1);
    push_byte(1, 8'h11, 1'b1, 1'b1);
    push_byte(2, 8'h12, 1'b1, 1'b1);
    push_byte(3, 8'h13, 1'b1, 1'b1);
    push_byte(0, 8'h20, 1'b1, 1'b1);
    push_byte(1, 8'h21, 1'b1, 1'b1);
    refresh();
    run_until_empty(40, n);
    chk("fair_cycles", 32'(n), 32'd12);

    // Backpressure: tx_ready toggles while requester 2 waits
    do_reset();
    bp_mode = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(1, 8'hB0 + 8'(i), (i == 3), 1'b1);
    push_byte(2, 8'hE2, 1'b1, 1'b1);
    refresh();
    run_until_empty(40, n);
    bp_mode  = 1'b0;
    tx_ready = 1'b1;
    cycle();

    // Reset mid-message: 5-byte message, reset after byte 2
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(0, 8'h50 + 8'(i), (i == 4), (i < 2));
    refresh();
    n = 0;
    while (head[0] < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("mid_two_bytes", 32'(head[0]), 32'd2);
    reset    = 1'b1;
    tx_ready = 1'b0;
    cycle();
    reset    = 1'b0;
    tx_ready = 1'b1;
    clear_queues();
    refresh();
    cycle();
    chk("mid_rst_txv", 32'(s_tx_valid), 32'd0);
    chk("mid_rst_grant", 32'(s_grant), 32'd0);
    chk("mid_rst_busy", 32'(s_busy), 32'd0);
    push_byte(1, 8'h77, 1'b1, 1'b1);
    refresh();
    cycle();
    cycle();
    chk("post_rst_grant", 32'(s_grant), 32'd2);
    chk("post_rst_txv", 32'(s_tx_valid), 32'd1);
    run_until_empty(10, n);

    // Idle gap of 5 cycles between two queued 1-byte messages
    do_reset();
    g_req_valid = 2'b11;
    g_req_data  = {8'h22, 8'h11};
    g_req_last  = 2'b11;
    t_first  = -1;
    t_second = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (t_first >= 0 && k == t_first + 1) begin
        chk("gap_busy", 32'(g_busy), 32'd1);
        chk("gap_txv", 32'(g_tx_valid), 32'd0);
      end
      if (t_first < 0 && g_tx_valid && g_req_ready[0]) begin
        t_first = k;
        chk("gap_first_data", 32'(g_tx_data), 32'h11);
      end else if (t_first >= 0 && t_second < 0 && g_tx_valid) begin
        t_second = k;
        chk("gap_second_data", 32'(g_tx_data), 32'h22);
        chk("gap_second_grant", 32'(g_grant), 32'd2);
      end
      @(posedge clk);
      #1;
      if (k == t_first)  g_req_valid[0] = 1'b0;
      if (k == t_second) g_req_valid[1] = 1'b0;
    end
    chk("gap_first_cycle", 32'(t_first), 32'd1);
    chk("gap_spacing", 32'(t_second - t_first), 32'd7);

    cycle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

`default_nettype wire
